// File: rtl/stdp_pkg.sv
// Shared definitions for the STDP learning slice.
// Holds the network dimensions, the packed weight-bus lane layout and the
// postsynaptic neuron state encoding used by lif_post_neuron.
package stdp_pkg;

    localparam int unsigned NUM_PRE_NEURONS = 4;
    localparam int unsigned W_BITS          = 4;
    localparam int unsigned POT_BITS        = 8;

    // Packed weight bus: lane 0 sits in the most significant nibble.
    localparam int unsigned WBUS_BITS = NUM_PRE_NEURONS * W_BITS;
    // Sum of four W_BITS weights never exceeds W_BITS+2 bits.
    localparam int unsigned SUM_BITS  = W_BITS + 2;

    // LSB position of weight lane i on the packed bus.
    function automatic int unsigned lane_lsb(input int unsigned i);
        return (NUM_PRE_NEURONS - 1 - i) * W_BITS;
    endfunction

    typedef enum logic {
        INTEGRATE  = 1'b0,
        REFRACTORY = 1'b1
    } neuron_state_t;

endpackage

// File: rtl/lif_post_neuron_if.sv
// Synaptic input / neuron output bundle between the STDP weight stage
// and the postsynaptic neuron.
//   pre_spike   : presynaptic spike vector (bit i pairs with weight lane i)
//   weight      : packed weights, lane 0 at the top nibble
//   post_spike  : single-cycle fire pulse
//   membrane    : registered membrane potential
//   refractory  : high while the neuron is refractory
//   spike_count : fires since reset, wraps at 255
// master drives the synaptic side, slave is the neuron.
interface lif_post_neuron_if;
    import stdp_pkg::*;

    logic [NUM_PRE_NEURONS-1:0] pre_spike;
    logic [WBUS_BITS-1:0]       weight;
    logic                       post_spike;
    logic [POT_BITS-1:0]        membrane;
    logic                       refractory;
    logic [7:0]                 spike_count;

    modport master (
        output pre_spike, weight,
        input  post_spike, membrane, refractory, spike_count
    );

    modport slave (
        input  pre_spike, weight,
        output post_spike, membrane, refractory, spike_count
    );

endinterface

// File: rtl/lif_post_neuron_syn_input_sum.sv
// Combinational synaptic input summation.
//   pre_spike : presynaptic spike vector
//   weight    : packed weight bus (lane i at lane_lsb(i))
//   sum       : sum of weights whose spike bit is set
module syn_input_sum
    import stdp_pkg::*;
(
    input  logic [NUM_PRE_NEURONS-1:0] pre_spike,
    input  logic [WBUS_BITS-1:0]       weight,
    output logic [SUM_BITS-1:0]        sum
);

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < NUM_PRE_NEURONS; i++) begin
            if (pre_spike[i]) begin
                sum = sum + SUM_BITS'(weight[lane_lsb(i) +: W_BITS]);
            end
        end
    end

endmodule

// File: rtl/lif_post_neuron.sv
// Leaky integrate-and-fire postsynaptic neuron.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of lif_post_neuron_if (spikes/weights in,
//         post_spike/membrane/refractory/spike_count out)
// Integrates gated weights with a constant leak, saturates the potential,
// fires on reaching THRESHOLD and then blanks input for REFRACT_CYCLES.
module lif_post_neuron
    import stdp_pkg::*;
#(
    parameter int unsigned THRESHOLD      = 40,
    parameter int unsigned LEAK           = 1,
    parameter int unsigned REFRACT_CYCLES = 4
) (
    input logic               clk,
    input logic               rst,
    lif_post_neuron_if.slave  bus
);

    localparam int unsigned CNT_BITS = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;
    localparam logic [POT_BITS:0]   LEAK_W = (POT_BITS + 1)'(LEAK);
    localparam logic [POT_BITS:0]   THR_W  = (POT_BITS + 1)'(THRESHOLD);
    localparam logic [POT_BITS:0]   SAT_W  = {1'b0, {POT_BITS{1'b1}}};
    localparam logic [CNT_BITS-1:0] REFR_LOAD = CNT_BITS'(REFRACT_CYCLES - 1);

    neuron_state_t        state, state_n;
    logic [CNT_BITS-1:0]  refr_cnt, refr_cnt_n;
    logic [POT_BITS-1:0]  membrane, membrane_n;
    logic                 post_spike, post_spike_n;
    logic [7:0]           spike_count, spike_count_n;

    logic [SUM_BITS-1:0]  sum;
    logic [POT_BITS:0]    acc_raw, acc_leak, acc;

    syn_input_sum u_sum (
        .pre_spike (bus.pre_spike),
        .weight    (bus.weight),
        .sum       (sum)
    );

    // One spare bit above the potential so leak and saturation see the
    // true sum before it is clipped.
    always_comb begin
        acc_raw  = {1'b0, membrane} + (POT_BITS + 1)'(sum);
        acc_leak = (acc_raw >= LEAK_W) ? (acc_raw - LEAK_W) : '0;
        acc      = (acc_leak > SAT_W) ? SAT_W : acc_leak;
    end

    always_comb begin
        state_n       = state;
        refr_cnt_n    = refr_cnt;
        membrane_n    = membrane;
        post_spike_n  = 1'b0;
        spike_count_n = spike_count;
        case (state)
            INTEGRATE: begin
                if (acc >= THR_W) begin
                    membrane_n    = '0;
                    post_spike_n  = 1'b1;
                    spike_count_n = spike_count + 8'd1;
                    refr_cnt_n    = REFR_LOAD;
                    state_n       = REFRACTORY;
                end else begin
                    membrane_n = acc[POT_BITS-1:0];
                end
            end
            REFRACTORY: begin
                membrane_n = '0;
                if (refr_cnt != '0) begin
                    refr_cnt_n = refr_cnt - 1'b1;
                end else begin
                    state_n = INTEGRATE;
                end
            end
            default: begin
                state_n = INTEGRATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INTEGRATE;
            refr_cnt    <= '0;
            membrane    <= '0;
            post_spike  <= 1'b0;
            spike_count <= '0;
        end else begin
            state       <= state_n;
            refr_cnt    <= refr_cnt_n;
            membrane    <= membrane_n;
            post_spike  <= post_spike_n;
            spike_count <= spike_count_n;
        end
    end

    assign bus.membrane    = membrane;
    assign bus.post_spike  = post_spike;
    assign bus.spike_count = spike_count;
    // state is a register, so this is as clean as a separate flop.
    assign bus.refractory  = (state == REFRACTORY);

endmodule

// File: tb/tb_lif_post_neuron.sv
// Directed self-checking bench for lif_post_neuron.
// dut_a uses THRESHOLD=40, dut_s uses THRESHOLD=255 for saturation cases.
module tb_lif_post_neuron;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    lif_post_neuron_if bus_a ();
    lif_post_neuron_if bus_s ();

    lif_post_neuron #(.THRESHOLD(40), .LEAK(1), .REFRACT_CYCLES(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    lif_post_neuron #(.THRESHOLD(255), .LEAK(1), .REFRACT_CYCLES(4)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus_a.pre_spike = '0;
        bus_a.weight    = '0;
        bus_s.pre_spike = '0;
        bus_s.weight    = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if (bus_a.membrane !== 8'd0) $display("FAIL reset_membrane cyc %0d: got %0d expected 0", c, bus_a.membrane);
            else passed++;
            total++;
            if (bus_a.post_spike !== 1'b0) $display("FAIL reset_post cyc %0d: got %b expected 0", c, bus_a.post_spike);
            else passed++;
            total++;
            if (bus_a.refractory !== 1'b0) $display("FAIL reset_refr cyc %0d: got %b expected 0", c, bus_a.refractory);
            else passed++;
            total++;
            if (bus_a.spike_count !== 8'd0) $display("FAIL reset_count cyc %0d: got %0d expected 0", c, bus_a.spike_count);
            else passed++;
        end
    endtask

    // pre_spike[3] pairs with lane 3 (bits [3:0]); lane 0 is bits [15:12].
    task automatic test_lane_map();
        do_reset();
        bus_a.pre_spike = 4'b1000;
        bus_a.weight    = 16'hA000;
        tick();
        total++;
        if (bus_a.membrane !== 8'd0) $display("FAIL lane_map_mismatch: got %0d expected 0", bus_a.membrane);
        else passed++;
        bus_a.weight = 16'h000A;
        tick();
        total++;
        if (bus_a.membrane !== 8'd9) $display("FAIL lane_map_lane3: got %0d expected 9", bus_a.membrane);
        else passed++;
    endtask

    task automatic test_single_lane();
        do_reset();
        bus_a.pre_spike = 4'b0001;
        bus_a.weight    = 16'hA000;
        for (int e = 1; e <= 4; e++) begin
            tick();
            total++;
            if (bus_a.membrane !== 8'(9 * e) || bus_a.post_spike !== 1'b0)
                $display("FAIL single_integrate edge %0d: got mem %0d post %b expected mem %0d post 0",
                         e, bus_a.membrane, bus_a.post_spike, 9 * e);
            else passed++;
        end
        tick();
        total++;
        if (bus_a.membrane !== 8'd0 || bus_a.post_spike !== 1'b1 || bus_a.spike_count !== 8'd1 || bus_a.refractory !== 1'b1)
            $display("FAIL single_fire: got mem %0d post %b cnt %0d refr %b expected 0 1 1 1",
                     bus_a.membrane, bus_a.post_spike, bus_a.spike_count, bus_a.refractory);
        else passed++;
        for (int e = 6; e <= 8; e++) begin
            tick();
            total++;
            if (bus_a.membrane !== 8'd0 || bus_a.post_spike !== 1'b0 || bus_a.refractory !== 1'b1)
                $display("FAIL single_refr edge %0d: got mem %0d post %b refr %b expected 0 0 1",
                         e, bus_a.membrane, bus_a.post_spike, bus_a.refractory);
            else passed++;
        end
        tick();
        total++;
        if (bus_a.membrane !== 8'd0 || bus_a.refractory !== 1'b0)
            $display("FAIL single_exit: got mem %0d refr %b expected 0 0", bus_a.membrane, bus_a.refractory);
        else passed++;
        tick();
        total++;
        if (bus_a.membrane !== 8'd9 || bus_a.spike_count !== 8'd1)
            $display("FAIL single_resume: got mem %0d cnt %0d expected 9 1", bus_a.membrane, bus_a.spike_count);
        else passed++;
    endtask

    task automatic test_all_lanes();
        logic       exp_post;
        logic       exp_refr;
        logic [7:0] exp_cnt;
        do_reset();
        bus_a.pre_spike = 4'hF;
        bus_a.weight    = 16'hFFFF;
        for (int e = 1; e <= 11; e++) begin
            tick();
            exp_post = ((e % 5) == 1);
            exp_refr = (((e - 1) % 5) < 4);
            exp_cnt  = 8'((e + 4) / 5);
            total++;
            if (bus_a.post_spike !== exp_post || bus_a.refractory !== exp_refr ||
                bus_a.spike_count !== exp_cnt || bus_a.membrane !== 8'd0)
                $display("FAIL all_lanes edge %0d: got post %b refr %b cnt %0d mem %0d expected %b %b %0d 0",
                         e, bus_a.post_spike, bus_a.refractory, bus_a.spike_count, bus_a.membrane,
                         exp_post, exp_refr, exp_cnt);
            else passed++;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        bus_s.pre_spike = 4'hF;
        bus_s.weight    = 16'hFFFF;
        for (int e = 1; e <= 4; e++) begin
            tick();
            total++;
            if (bus_s.membrane !== 8'(59 * e) || bus_s.post_spike !== 1'b0)
                $display("FAIL sat_integrate edge %0d: got mem %0d post %b expected mem %0d post 0",
                         e, bus_s.membrane, bus_s.post_spike, 59 * e);
            else passed++;
        end
        tick();
        total++;
        if (bus_s.membrane !== 8'd0 || bus_s.post_spike !== 1'b1 || bus_s.spike_count !== 8'd1)
            $display("FAIL sat_fire: got mem %0d post %b cnt %0d expected 0 1 1",
                     bus_s.membrane, bus_s.post_spike, bus_s.spike_count);
        else passed++;
    endtask

    // Continues from test_saturation: dut_s fired at edge 5, input still held.
    task automatic test_refractory_blanking();
        for (int e = 6; e <= 9; e++) begin
            tick();
            total++;
            if (bus_s.membrane !== 8'd0 || bus_s.post_spike !== 1'b0 || bus_s.refractory !== (e != 9))
                $display("FAIL blank edge %0d: got mem %0d post %b refr %b expected 0 0 %b",
                         e, bus_s.membrane, bus_s.post_spike, bus_s.refractory, (e != 9));
            else passed++;
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++;
            if (bus_s.membrane !== 8'(59 * k) || bus_s.post_spike !== 1'b0)
                $display("FAIL blank_resume step %0d: got mem %0d post %b expected %0d 0",
                         k, bus_s.membrane, bus_s.post_spike, 59 * k);
            else passed++;
        end
        tick();
        total++;
        if (bus_s.post_spike !== 1'b1 || bus_s.spike_count !== 8'd2 || bus_s.membrane !== 8'd0)
            $display("FAIL blank_refire: got post %b cnt %0d mem %0d expected 1 2 0",
                     bus_s.post_spike, bus_s.spike_count, bus_s.membrane);
        else passed++;
    endtask

    task automatic test_mid_refractory_reset();
        do_reset();
        bus_a.pre_spike = 4'hF;
        bus_a.weight    = 16'hFFFF;
        tick();
        tick();
        total++;
        if (bus_a.refractory !== 1'b1 || bus_a.spike_count !== 8'd1)
            $display("FAIL midrst_pre: got refr %b cnt %0d expected 1 1", bus_a.refractory, bus_a.spike_count);
        else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus_a.refractory !== 1'b0 || bus_a.spike_count !== 8'd0 || bus_a.membrane !== 8'd0 || bus_a.post_spike !== 1'b0)
            $display("FAIL midrst_after: got refr %b cnt %0d mem %0d post %b expected 0 0 0 0",
                     bus_a.refractory, bus_a.spike_count, bus_a.membrane, bus_a.post_spike);
        else passed++;
        // Back in INTEGRATE immediately: held input fires on the next edge.
        tick();
        total++;
        if (bus_a.post_spike !== 1'b1 || bus_a.spike_count !== 8'd1)
            $display("FAIL midrst_integrate: got post %b cnt %0d expected 1 1", bus_a.post_spike, bus_a.spike_count);
        else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        bus_a.pre_spike = 4'hF;
        bus_a.weight    = 16'hFFFF;
        tick();
        total++;
        if (bus_a.spike_count !== 8'd1) $display("FAIL wrap_first: got %0d expected 1", bus_a.spike_count);
        else passed++;
        repeat (254 * 5) tick();
        total++;
        if (bus_a.spike_count !== 8'd255 || bus_a.post_spike !== 1'b1)
            $display("FAIL wrap_255: got cnt %0d post %b expected 255 1", bus_a.spike_count, bus_a.post_spike);
        else passed++;
        repeat (5) tick();
        total++;
        if (bus_a.spike_count !== 8'd0 || bus_a.post_spike !== 1'b1)
            $display("FAIL wrap_zero: got cnt %0d post %b expected 0 1", bus_a.spike_count, bus_a.post_spike);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        bus_a.pre_spike = '0;
        bus_a.weight    = '0;
        bus_s.pre_spike = '0;
        bus_s.weight    = '0;
        test_reset();
        test_lane_map();
        test_single_lane();
        test_all_lanes();
        test_saturation();
        test_refractory_blanking();
        test_mid_refractory_reset();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
